// File: rtl/kl8e_tty.sv
// KL8E-style console terminal: keyboard receive buffer, teleprinter
// transmit buffer and IOT decode for a PDP-8 CPU.
module kl8e_tty #(
    parameter logic [5:0] KBD_DEV = 6'o03,
    parameter logic [5:0] TTO_DEV = 6'o04
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic        iotStb,
    input  logic [11:0] iotInstr,
    input  logic [11:0] acIn,
    output logic [11:0] acOut,
    output logic        acWrite,
    output logic        skip,
    output logic        iotDone,
    output logic        irq,
    output logic [7:0]  txData,
    output logic        txStb,
    input  logic        txRdy,
    input  logic [7:0]  rxData,
    input  logic        rxRdy,
    output logic        rxAck
);

    typedef enum logic [1:0] {IDLE, WAIT, BUSY} ttoState_t;

    ttoState_t  state, stateNext;
    logic [7:0] kbdBuf, ttoBuf;
    logic       kbdFlag, ttoFlag, ie, again, againNext, fresh;
    logic       isIot, kbdSel, ttoSel, capture, print, ttoDone;
    logic [2:0] fn;
    logic       kcf, ksf, kcc, krs, kie, krb;
    logic       tfl, tsf, tcf, tpc, tsk, tls;

    assign isIot  = iotStb & (iotInstr[11:9] == 3'o6);
    assign kbdSel = isIot & (iotInstr[8:3] == KBD_DEV);
    assign ttoSel = isIot & (iotInstr[8:3] == TTO_DEV);
    assign fn     = iotInstr[2:0];

    assign kcf = kbdSel & (fn == 3'd0);
    assign ksf = kbdSel & (fn == 3'd1);
    assign kcc = kbdSel & (fn == 3'd2);
    assign krs = kbdSel & (fn == 3'd4);
    assign kie = kbdSel & (fn == 3'd5);
    assign krb = kbdSel & (fn == 3'd6);
    assign tfl = ttoSel & (fn == 3'd0);
    assign tsf = ttoSel & (fn == 3'd1);
    assign tcf = ttoSel & (fn == 3'd2);
    assign tpc = ttoSel & (fn == 3'd4);
    assign tsk = ttoSel & (fn == 3'd5);
    assign tls = ttoSel & (fn == 3'd6);

    assign capture = rxRdy & ~rxAck;
    assign print   = tpc | tls;
    assign irq     = ie & (kbdFlag | ttoFlag);
    assign txData  = ttoBuf;

    // A print landing while a byte is leaving is held in again and resent
    always_comb begin
        stateNext = state;
        againNext = again;
        txStb     = 1'b0;
        ttoDone   = 1'b0;
        case (state)
            IDLE: begin
                if (print) stateNext = WAIT;
            end
            WAIT: begin
                if (txRdy) begin
                    txStb     = 1'b1;
                    againNext = print;
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                if (!fresh && txRdy) begin
                    againNext = 1'b0;
                    if (again || print) begin
                        stateNext = WAIT;
                    end else begin
                        ttoDone   = 1'b1;
                        stateNext = IDLE;
                    end
                end else if (print) begin
                    againNext = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state   <= IDLE;
            again   <= 1'b0;
            fresh   <= 1'b0;
            kbdBuf  <= 8'd0;
            kbdFlag <= 1'b0;
            ttoBuf  <= 8'd0;
            ttoFlag <= 1'b0;
            ie      <= 1'b1;
            rxAck   <= 1'b0;
            iotDone <= 1'b0;
            skip    <= 1'b0;
            acWrite <= 1'b0;
            acOut   <= 12'd0;
        end else begin
            state <= stateNext;
            again <= againNext;
            fresh <= txStb;
            rxAck <= capture;
            if (print) ttoBuf <= acIn[7:0];
            if (capture) kbdBuf <= rxData;
            if (capture) kbdFlag <= 1'b1;
            else if (kcf | kcc | krb) kbdFlag <= 1'b0;
            if (ttoDone | tfl) ttoFlag <= 1'b1;
            else if (tcf | tls) ttoFlag <= 1'b0;
            if (kie) ie <= acIn[0];
            iotDone <= kbdSel | ttoSel;
            skip    <= (ksf & kbdFlag) | (tsf & ttoFlag)
                     | (tsk & (ttoFlag | kbdFlag));
            acWrite <= kcc | krs | krb;
            if (krs) acOut <= acIn | {4'd0, kbdBuf};
            else if (krb) acOut <= {4'd0, kbdBuf};
            else acOut <= 12'd0;
        end
    end

endmodule

// File: tb/tb_kl8e_tty.sv
// Bench for kl8e_tty: uart stand-in, event-level reference model,
// directed scenarios and randomized IOT/receive traffic.
module tb_kl8e_tty;

    logic        SYSCLK = 1'b0;
    logic        RESET = 1'b1;
    logic        iotStb = 1'b0;
    logic [11:0] iotInstr = 12'd0;
    logic [11:0] acIn = 12'd0;
    logic [11:0] acOut;
    logic        acWrite, skip, iotDone, irq, txStb, rxAck;
    logic [7:0]  txData;
    logic        txRdy;
    logic [7:0]  rxData = 8'd0;
    logic        rxRdy = 1'b0;

    kl8e_tty dut (
        .SYSCLK(SYSCLK), .RESET(RESET), .iotStb(iotStb),
        .iotInstr(iotInstr), .acIn(acIn), .acOut(acOut),
        .acWrite(acWrite), .skip(skip), .iotDone(iotDone), .irq(irq),
        .txData(txData), .txStb(txStb), .txRdy(txRdy),
        .rxData(rxData), .rxRdy(rxRdy), .rxAck(rxAck)
    );

    always #5 SYSCLK = ~SYSCLK;

    localparam logic [5:0] KBD = 6'o03;
    localparam logic [5:0] TTO = 6'o04;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // uart stand-in
    logic uRdy = 1'b1;
    logic forceLow = 1'b0;
    int   lowLeft = 0;
    int   txLen = 5;
    bit   rxAuto = 0;
    logic prevStb, prevAck;
    assign txRdy = uRdy & ~forceLow;

    task automatic tick();
        @(negedge SYSCLK);
        prevStb = txStb;
        prevAck = rxAck;
        @(posedge SYSCLK);
        #1;
        if (prevStb) begin
            lowLeft = txLen;
            uRdy = 1'b1;
        end else if (lowLeft > 0) begin
            uRdy = 1'b0;
            lowLeft--;
        end else begin
            uRdy = 1'b1;
        end
        if (prevAck) begin
            rxRdy = 1'b0;
        end else if (rxAuto && !rxRdy && ($urandom_range(0, 7) == 0)) begin
            rxRdy = 1'b1;
            rxData = 8'($urandom);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic iot(input logic [5:0] dev, input logic [2:0] f,
                       input logic [11:0] ac);
        iotStb = 1'b1;
        iotInstr = {3'o6, dev, f};
        acIn = ac;
        tick();
        iotStb = 1'b0;
        iotInstr = 12'd0;
        acIn = 12'd0;
    endtask

    // reference model: flags, buffers and the pending-print rule
    bit         mKF, mTF, mIe, mAck, mDone, mSkip, mAcW;
    logic [11:0] mAcOut;
    logic [7:0] mKB, pendData;
    bit         pend, elig, inflight;
    int         age;
    int         ackCnt = 0;
    logic [7:0] txLog[$];

    bit         cap, isK, isT, prt, stb, cpl, hw, nInfl;
    logic [2:0] f3;

    always @(negedge SYSCLK) begin
        if (RESET) begin
            mKF = 0; mTF = 0; mIe = 1; mAck = 0;
            mDone = 0; mSkip = 0; mAcW = 0; mAcOut = 12'd0;
            mKB = 8'd0; pendData = 8'd0;
            pend = 0; elig = 0; inflight = 0; age = 0;
        end else begin
            stb = pend && elig && txRdy;
            chk("rxAck", rxAck, mAck);
            chk("iotDone", iotDone, mDone);
            chk("skip", skip, mSkip);
            chk("acWrite", acWrite, mAcW);
            chk("acOut", acOut, mAcOut);
            chk("irq", irq, mIe && (mKF || mTF));
            chk("txStb", txStb, stb);
            if (stb) chk("txData", txData, pendData);
            if (rxAck) ackCnt++;
            if (txStb) txLog.push_back(txData);

            cap = rxRdy && !mAck;
            isK = iotStb && iotInstr[11:9] == 3'o6 && iotInstr[8:3] == KBD;
            isT = iotStb && iotInstr[11:9] == 3'o6 && iotInstr[8:3] == TTO;
            f3 = iotInstr[2:0];
            prt = isT && (f3 == 4 || f3 == 6);
            cpl = inflight && age >= 1 && txRdy;
            hw = cpl && !pend && !prt;

            mDone = isK || isT;
            mSkip = (isK && f3 == 1 && mKF) || (isT && f3 == 1 && mTF)
                  || (isT && f3 == 5 && (mTF || mKF));
            mAcW = isK && (f3 == 2 || f3 == 4 || f3 == 6);
            if (!mAcW || f3 == 2) mAcOut = 12'd0;
            else if (f3 == 4) mAcOut = acIn | {4'd0, mKB};
            else mAcOut = {4'd0, mKB};

            if (hw || (isT && f3 == 0)) mTF = 1;
            else if (isT && (f3 == 2 || f3 == 6)) mTF = 0;
            if (cap) mKF = 1;
            else if (isK && (f3 == 0 || f3 == 2 || f3 == 6)) mKF = 0;
            if (cap) mKB = rxData;
            if (isK && f3 == 5) mIe = acIn[0];
            mAck = cap;

            nInfl = stb ? 1 : (cpl ? 0 : inflight);
            if (prt) begin
                pend = 1;
                pendData = acIn[7:0];
                elig = !nInfl;
            end else if (stb) begin
                pend = 0;
                elig = 0;
            end else if (cpl) begin
                elig = pend;
            end
            inflight = nInfl;
            if (stb) age = 0;
            else age++;
        end
    end

    initial begin
        RESET = 1'b1;
        ticks(3);
        RESET = 1'b0;
        ticks(2);
        chk("rst irq", irq, 0);
        chk("rst txStb", txStb, 0);
        chk("rst acOut", acOut, 0);

        iot(TTO, 3'd1, 12'd0);
        chk("TSF idle skip", skip, 0);
        chk("TSF iotDone", iotDone, 1);
        iot(TTO, 3'd0, 12'd0);
        iot(TTO, 3'd1, 12'd0);
        chk("TFL TSF skip", skip, 1);
        chk("TFL irq", irq, 1);
        iot(TTO, 3'd2, 12'd0);
        chk("TCF irq", irq, 0);

        ackCnt = 0;
        rxData = 8'hC1;
        rxRdy = 1'b1;
        ticks(5);
        chk("ack once", ackCnt, 1);
        iot(KBD, 3'd1, 12'd0);
        chk("KSF skip", skip, 1);
        iot(KBD, 3'd6, 12'o7777);
        chk("KRB acOut", acOut, 12'o0301);
        chk("KRB acWrite", acWrite, 1);
        iot(KBD, 3'd1, 12'd0);
        chk("KSF after KRB", skip, 0);

        rxData = 8'h0A;
        rxRdy = 1'b1;
        ticks(4);
        iot(KBD, 3'd4, 12'o4000);
        chk("KRS acOut", acOut, 12'o4012);
        iot(KBD, 3'd1, 12'd0);
        chk("KRS keeps flag", skip, 1);
        iot(KBD, 3'd5, 12'd0);
        chk("KIE0 irq", irq, 0);
        rxData = 8'h0B;
        rxRdy = 1'b1;
        ticks(4);
        chk("KIE0 new byte irq", irq, 0);
        iot(KBD, 3'd5, 12'd1);
        chk("KIE1 irq", irq, 1);
        iot(KBD, 3'd0, 12'd0);
        chk("KCF irq", irq, 0);

        txLen = 100;
        txLog.delete();
        iot(TTO, 3'd6, 12'o0101);
        chk("TLS txStb", txStb, 1);
        chk("TLS txData", txData, 8'h41);
        ticks(50);
        chk("busy irq", irq, 0);
        ticks(60);
        chk("done irq", irq, 1);
        iot(TTO, 3'd1, 12'd0);
        chk("done TSF", skip, 1);

        txLen = 20;
        txLog.delete();
        iot(TTO, 3'd6, 12'h041);
        ticks(3);
        iot(TTO, 3'd6, 12'h042);
        ticks(25);
        chk("two strobes", txLog.size(), 2);
        chk("flag after first", irq, 0);
        ticks(25);
        chk("flag after second", irq, 1);
        if (txLog.size() == 2) begin
            chk("byte0", txLog[0], 8'h41);
            chk("byte1", txLog[1], 8'h42);
        end
        iot(TTO, 3'd2, 12'd0);

        rxData = 8'h55;
        rxRdy = 1'b1;
        iot(KBD, 3'd0, 12'd0);
        ticks(2);
        iot(KBD, 3'd1, 12'd0);
        chk("capture beats KCF", skip, 1);
        iot(KBD, 3'd6, 12'd0);
        chk("KRB 55", acOut, 12'o0125);

        forceLow = 1'b1;
        txLog.delete();
        iot(TTO, 3'd6, 12'h033);
        ticks(3);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        forceLow = 1'b0;
        ticks(10);
        chk("no strobe after reset", txLog.size(), 0);
        iot(TTO, 3'd1, 12'd0);
        chk("reset ttoFlag", skip, 0);

        rxAuto = 1;
        for (int n = 0; n < 600; n++) begin
            int r;
            r = $urandom_range(0, 9);
            txLen = $urandom_range(2, 12);
            if (r <= 3) begin
                iot(KBD, 3'($urandom), 12'($urandom));
            end else if (r <= 7) begin
                iot(TTO, 3'($urandom), 12'($urandom));
            end else if (r == 8) begin
                iot(6'($urandom_range(5, 63)), 3'($urandom), 12'($urandom));
            end else begin
                ticks($urandom_range(1, 20));
            end
        end
        rxAuto = 0;
        ticks(200);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/kl8e_tty.md
# kl8e_tty

PDP-8 console terminal controller in the KL8E style. It sits between the CPU's IOT bus and the byte-wide handshake of the serial `uart` block. It takes received bytes from the uart into a keyboard buffer and raises the keyboard flag. It decodes keyboard and teleprinter IOT instructions, and feeds printed characters to the uart transmitter with a teleprinter-done flag and interrupt request.

## Interface
- `KBD_DEV`, default 6'o03: keyboard device code, matched against `iotInstr[8:3]`.
- `TTO_DEV`, default 6'o04: teleprinter device code.

- `SYSCLK`: in, 1. System clock.
- `RESET`: in, 1. Reset is asynchronous and active-high.
- `iotStb`: in, 1. Pulse lasting one SYSCLK; `iotInstr` is valid in that cycle.
- `iotInstr`: in, 12. IOT word. `[11:9]` = 3'o6, `[8:3]` = device, `[2:0]` = function.
- `acIn`: in, 12. CPU AC. `acIn[0]` is PDP bit 11 (LSB).
- `acOut`: out, 12. New AC value. Reset 0.
- `acWrite`: out, 1. CPU loads `acOut` into AC. Reset 0.
- `skip`: out, 1. CPU skips the next instruction. Reset 0.
- `iotDone`: out, 1. Marks the response cycle. Reset 0.
- `irq`: out, 1. Interrupt request. Reset 0.
- `txData`: out, 8. Byte to the uart transmitter. Reset 0.
- `txStb`: out, 1. Strobe lasting one SYSCLK. Reset 0.
- `txRdy`: in, 1. Uart transmitter can accept a byte.
- `rxData`: in, 8. Byte from the uart receiver.
- `rxRdy`: in, 1. Uart holds a received byte.
- `rxAck`: out, 1. Pulse lasting one SYSCLK; releases the byte. Reset 0.

## Operation
- Registers:
  - `kbdBuf[7:0]`
  - `kbdFlag`
  - `ttoBuf[7:0]`
  - `ttoFlag`
  - `ie`, which resets to 1
  - `again`
  - the TTO FSM
  - All other registers reset to 0. `irq = ie & (kbdFlag | ttoFlag)`.
- Receive path:
  - Capture when `rxRdy & ~rxAck`: `kbdBuf <= rxData`, `kbdFlag <= 1`, `rxAck <= 1` for one cycle.
  - If `kbdFlag` is already set, the buffer is overwritten (overrun) and the flag stays 1.
- Keyboard IOTs (device `KBD_DEV`):
  - 0 KCF: clear `kbdFlag`.
  - 1 KSF: skip if `kbdFlag`.
  - 2 KCC: AC = 0, clear `kbdFlag`.
  - 4 KRS: AC = `acIn | kbdBuf`.
  - 5 KIE: `ie <= acIn[0]`.
  - 6 KRB: AC = `{4'b0, kbdBuf}`, clear `kbdFlag`.
  - 3 and 7: no-op, but `iotDone` still pulses.
- Teleprinter IOTs (device `TTO_DEV`):
  - 0 TFL: set `ttoFlag`.
  - 1 TSF: skip if `ttoFlag`.
  - 2 TCF: clear `ttoFlag`.
  - 4 TPC: print `acIn[7:0]`.
  - 5 TSK: skip if `ttoFlag | kbdFlag`.
  - 6 TLS: clear `ttoFlag`, then print.
  - 3 and 7: no-op.
- Other devices: no response; all IOT outputs stay 0.
- TTO FSM:
  - IDLE: on a print, latch `ttoBuf`, go to WAIT.
  - WAIT: on a print, overwrite `ttoBuf`. When `txRdy`, drive `txData = ttoBuf`, `txStb = 1`, go to BUSY.
  - BUSY: on a print, overwrite `ttoBuf` and set `again`. When `txRdy`:
    - If `again`, clear `again`, go to WAIT, and leave `ttoFlag` unchanged.
    - Otherwise set `ttoFlag` and go to IDLE.
  - `txRdy` is ignored in the first BUSY cycle, because the uart drops it one cycle after the strobe.
- Simultaneous events:
  - A hardware flag set wins over an IOT clear in the same cycle (KCF/KRB/KCC/TLS/TCF).
  - KRB/KRS in a capture cycle read the pre-capture `kbdBuf`. The flag ends up set.
  - A TLS in the cycle BUSY completes: print wins. `again` takes effect, and `ttoFlag` ends 0.
- Reset mid-operation: the FSM goes to IDLE and `txStb`/`rxAck` drop immediately. A uart frame already in flight is not aborted.

## Timing
- An IOT with `iotStb` in cycle N responds in cycle N+1: `iotDone=1` for exactly one cycle, plus `skip`, `acWrite`, `acOut`. Flag/`ie` changes are visible in N+1.
- `acWrite` is 1 only for KCC, KRS and KRB.
- Receive: `rxRdy` high in cycle N gives `rxAck` and `kbdFlag` in N+1. The uart drops `rxRdy` by N+2, and no second capture occurs.
- Print: TLS in N gives the FSM in WAIT at N+1. If `txRdy` is already 1, `txStb` fires at N+1. BUSY starts at N+2.
- `ttoFlag` is set in the cycle after BUSY sees `txRdy` (the uart raises `txRdy` in the stop bit).
- `irq` is combinational from the registers and follows flag changes in the same cycle.

## Test plan
- Reset, then idle: all outputs are 0 and `ie=1`. TSF gives `skip=0`. TFL then TSF gives `skip=1` and `irq=1`.
- Uart presents rxData=8'hC1 with rxRdy held until ack: `rxAck` pulses once, then KSF gives skip=1. KRB with acIn=12'o7777 gives acOut=12'o0301, acWrite=1, and kbdFlag=0.
- KRS with acIn=12'o4000 after byte 8'h0A: acOut=12'o4012, and kbdFlag stays 1. KIE with acIn=0, then a new byte: irq stays 0.
- TLS with acIn=12'o0101 while txRdy=1: txStb=1 with txData=8'h41 one cycle later. Hold txRdy low 100 cycles, then raise it: ttoFlag=1 and irq=1.
- TLS 8'h41, then TLS 8'h42 during BUSY: two strobes, 8'h41 then 8'h42. ttoFlag is set only after the second completes.
- Capture and KCF in the same cycle gives kbdFlag=1. Assert RESET during WAIT: txStb never fires and ttoFlag=0.
